// File: rtl/fifo_word_packer_if.sv
// Bundles the FIFO read side and the packed output stream of fifo_word_packer.
// master is the packer's view; slave is the surrounding environment's view.
interface fifo_word_packer_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned BEATS      = 4
);
    // FIFO read side
    logic                        fifo_empty;
    logic [DATA_WIDTH-1:0]       fifo_data;
    logic                        fifo_read_en;
    // Packed output stream
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH*BEATS-1:0] out_data;
    logic [BEATS-1:0]            out_keep;
    logic                        busy;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_read_en, out_valid, out_data, out_keep, busy
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_read_en, out_valid, out_data, out_keep, busy
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains a synchronous FIFO and packs BEATS consecutive words into one wide word.
// A partially filled word is flushed with a lane-keep mask after TIMEOUT idle cycles.
module fifo_word_packer #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned BEATS      = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic                clk,
    input logic                reset,
    fifo_word_packer_if.master bus
);
    localparam int unsigned CNT_W  = $clog2(BEATS + 1);
    localparam int unsigned OCC_W  = CNT_W + 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT);
    localparam int unsigned ACC_W  = DATA_WIDTH * BEATS;

    typedef enum logic {
        StFill,
        StEmit
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               pending_q;
    logic [OCC_W-1:0]   occupancy;
    logic               read_en;

    // Read issue: never let captured plus in-flight words exceed BEATS.
    always_comb begin
        occupancy = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pending_q};
        read_en   = !reset && (state_q == StFill) && !bus.fifo_empty &&
                    (occupancy < OCC_W'(BEATS));
    end

    // Next-state: capture, idle timeout and output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        acc_d   = acc_q;
        unique case (state_q)
            StFill: begin
                if (pending_q) begin
                    // A capture always wins over an expiring idle counter.
                    for (int i = 0; i < BEATS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            acc_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
                        end
                    end
                    cnt_d  = cnt_q + CNT_W'(1);
                    idle_d = '0;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = StEmit;
                    end
                end else if ((cnt_q != '0) && bus.fifo_empty) begin
                    if (idle_q == IDLE_W'(TIMEOUT - 2)) begin
                        state_d = StEmit;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            StEmit: begin
                if (bus.out_ready) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    idle_d  = '0;
                    acc_d   = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State registers; an in-flight read is dropped on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFill;
            cnt_q     <= '0;
            idle_q    <= '0;
            acc_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            acc_q     <= acc_d;
            pending_q <= read_en;
        end
    end

    // Outputs: word and keep are only presented while emitting.
    always_comb begin
        bus.fifo_read_en = read_en;
        bus.out_valid    = (state_q == StEmit);
        bus.out_data     = (state_q == StEmit) ? acc_q : '0;
        for (int i = 0; i < BEATS; i++) begin
            bus.out_keep[i] = (state_q == StEmit) && (CNT_W'(i) < cnt_q);
        end
        bus.busy = (cnt_q != '0) || pending_q || (state_q == StEmit);
    end
endmodule
